// File: rtl/interrupt_ctrl_if.sv
// Memory-mapped bus bundle shared by the mmap blocks (OR-combined read data).
interface interrupt_ctrl_if;
  logic [15:0] address;
  logic [7:0]  indata;
  logic [7:0]  outdata;
  logic        load;
  logic        store;

  modport master (
    output address,
    output indata,
    output load,
    output store,
    input  outdata
  );

  modport slave (
    input  address,
    input  indata,
    input  load,
    input  store,
    output outdata
  );
endinterface

// File: rtl/interrupt_ctrl.sv
// Interrupt controller: latches peripheral request pulses into IF (FF0F),
// holds the IE mask (FFFF) and the master enable IME, and runs the
// request/acknowledge/vector handshake with the CPU core.
module interrupt_ctrl #(
  parameter logic [15:0] IF_ADDR  = 16'hff0f,
  parameter logic [15:0] IE_ADDR  = 16'hffff,
  parameter logic [15:0] VEC_BASE = 16'h0040
) (
  input  logic                  clockgb,
  input  logic                  resetn,
  interrupt_ctrl_if.slave       bus,
  input  logic                  intv,
  input  logic                  intl,
  input  logic                  intt,
  input  logic                  ints,
  input  logic                  intj,
  input  logic                  ei,
  input  logic                  di,
  input  logic                  reti,
  input  logic                  iack,
  output logic                  irq,
  output logic [15:0]           ivector,
  output logic                  ivalid,
  output logic [4:0]            dif,
  output logic                  dime
);

  typedef enum logic {
    S_IDLE,
    S_DISPATCH
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_dispatch;

  logic [4:0]  r_if;
  logic [7:0]  r_ie;
  logic        r_ime;
  logic        r_ime_delay;
  logic [15:0] r_ivector;
  logic        r_ivalid;

  logic [4:0]  w_req;
  logic        w_if_wsel;
  logic        w_ie_wsel;
  logic [4:0]  w_if_wr;
  logic [7:0]  w_ie_wr;
  logic [4:0]  w_pend;
  logic [4:0]  w_pend_ack;
  logic [2:0]  w_sel;
  logic        w_found;
  logic [4:0]  w_clr_mask;
  logic [4:0]  w_if_next;

  assign w_req     = {intj, ints, intt, intl, intv};
  assign w_if_wsel = bus.store && (bus.address == IF_ADDR);
  assign w_ie_wsel = bus.store && (bus.address == IE_ADDR);

  // Dispatch selection looks at IF/IE with this cycle's CPU store already
  // applied, so a same-cycle write of 0 cancels the dispatch (vector 0000).
  assign w_if_wr    = w_if_wsel ? bus.indata[4:0] : r_if;
  assign w_ie_wr    = w_ie_wsel ? bus.indata      : r_ie;
  assign w_pend_ack = w_if_wr & w_ie_wr[4:0];
  assign w_pend     = r_if & r_ie[4:0];

  // Lowest set pending bit wins; bit 0 (vblank) has highest priority.
  always_comb begin
    w_sel   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      if (w_pend_ack[i] && !w_found) begin
        w_sel   = 3'(i);
        w_found = 1'b1;
      end
    end
  end

  // One-hot clear of the bit being dispatched (none when cancelled).
  always_comb begin
    w_clr_mask = '0;
    if (w_dispatch && w_found) begin
      w_clr_mask[w_sel] = 1'b1;
    end
  end

  // Per-bit priority: hardware set > dispatch clear > CPU store.
  assign w_if_next = (w_if_wr & ~w_clr_mask) | w_req;

  // FSM state register.
  always_ff @(posedge clockgb or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state and dispatch strobe.
  always_comb begin
    w_state_next = r_state;
    w_dispatch   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (iack) begin
          w_state_next = S_DISPATCH;
          w_dispatch   = 1'b1;
        end
      end
      S_DISPATCH: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // IF and IE registers.
  always_ff @(posedge clockgb or negedge resetn) begin
    if (!resetn) begin
      r_if <= '0;
      r_ie <= '0;
    end else begin
      r_if <= w_if_next;
      r_ie <= w_ie_wr;
    end
  end

  // Master enable: dispatch and DI clear at once, RETI sets at once,
  // EI sets one cycle late through ime_delay (DI in between cancels it).
  always_ff @(posedge clockgb or negedge resetn) begin
    if (!resetn) begin
      r_ime       <= 1'b0;
      r_ime_delay <= 1'b0;
    end else if (w_dispatch || di) begin
      r_ime       <= 1'b0;
      r_ime_delay <= 1'b0;
    end else begin
      if (reti || r_ime_delay) begin
        r_ime <= 1'b1;
      end
      r_ime_delay <= ei;
    end
  end

  // Vector output: captured at the iack edge and held until the next dispatch.
  always_ff @(posedge clockgb or negedge resetn) begin
    if (!resetn) begin
      r_ivector <= '0;
      r_ivalid  <= 1'b0;
    end else begin
      r_ivalid <= w_dispatch;
      if (w_dispatch) begin
        r_ivector <= w_found ? (VEC_BASE + {10'b0, w_sel, 3'b000}) : '0;
      end
    end
  end

  // Combinational bus read; zero when not addressed so it can be OR-combined.
  always_comb begin
    bus.outdata = '0;
    if (bus.load && (bus.address == IF_ADDR)) begin
      bus.outdata = {3'b111, r_if};
    end else if (bus.load && (bus.address == IE_ADDR)) begin
      bus.outdata = r_ie;
    end
  end

  assign irq     = (r_state == S_IDLE) && r_ime && (|w_pend);
  assign ivector = r_ivector;
  assign ivalid  = r_ivalid;
  assign dif     = r_if;
  assign dime    = r_ime;

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Directed-vector bench for interrupt_ctrl: one table record per clock cycle,
// plus a hand sequence for asynchronous reset during dispatch.
module tb_interrupt_ctrl;

  logic        clockgb;
  logic        resetn;
  logic        intv, intl, intt, ints, intj;
  logic        ei, di, reti, iack;
  logic        irq;
  logic [15:0] ivector;
  logic        ivalid;
  logic [4:0]  dif;
  logic        dime;

  interrupt_ctrl_if bus_if ();

  interrupt_ctrl #(
    .IF_ADDR  (16'hff0f),
    .IE_ADDR  (16'hffff),
    .VEC_BASE (16'h0040)
  ) dut (
    .clockgb (clockgb),
    .resetn  (resetn),
    .bus     (bus_if),
    .intv    (intv),
    .intl    (intl),
    .intt    (intt),
    .ints    (ints),
    .intj    (intj),
    .ei      (ei),
    .di      (di),
    .reti    (reti),
    .iack    (iack),
    .irq     (irq),
    .ivector (ivector),
    .ivalid  (ivalid),
    .dif     (dif),
    .dime    (dime)
  );

  initial clockgb = 1'b0;
  always #5 clockgb = ~clockgb;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic        st;
    logic        ld;
    logic [15:0] addr;
    logic [7:0]  din;
    logic [4:0]  req;
    logic        ei;
    logic        di;
    logic        reti;
    logic        iack;
    logic        e_irq;
    logic        e_ivalid;
    logic [15:0] e_vec;
    logic [4:0]  e_if;
    logic        e_ime;
    logic [7:0]  e_out;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(
    input logic st, input logic ld, input logic [15:0] addr, input logic [7:0] din,
    input logic [4:0] req, input logic e_i, input logic d_i, input logic rt, input logic ak,
    input logic x_irq, input logic x_ivalid, input logic [15:0] x_vec,
    input logic [4:0] x_if, input logic x_ime, input logic [7:0] x_out);
    vec_t v;
    v.st = st; v.ld = ld; v.addr = addr; v.din = din; v.req = req;
    v.ei = e_i; v.di = d_i; v.reti = rt; v.iack = ak;
    v.e_irq = x_irq; v.e_ivalid = x_ivalid; v.e_vec = x_vec;
    v.e_if = x_if; v.e_ime = x_ime; v.e_out = x_out;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus_if.store   = v.st;
    bus_if.load    = v.ld;
    bus_if.address = v.addr;
    bus_if.indata  = v.din;
    {intj, ints, intt, intl, intv} = v.req;
    ei   = v.ei;
    di   = v.di;
    reti = v.reti;
    iack = v.iack;
  endtask

  task automatic idle_inputs();
    vec_t v;
    v = mk(0, 0, 16'h0000, 8'h00, 5'h00, 0, 0, 0, 0, 0, 0, 16'h0000, 5'h00, 0, 8'h00);
    drive(v);
  endtask

  initial begin
    //          st ld addr      din    req    ei di rt ak | irq iv vec       IF     ime out
    vecs.push_back(mk(0, 1, 16'hff0f, 8'h00, 5'h00, 0, 0, 0, 0, 0, 0, 16'h0000, 5'h00, 0, 8'he0)); // 0 read IF
    vecs.push_back(mk(0, 1, 16'hffff, 8'h00, 5'h00, 0, 0, 0, 0, 0, 0, 16'h0000, 5'h00, 0, 8'h00)); // 1 read IE
    vecs.push_back(mk(1, 0, 16'hffff, 8'h04, 5'h00, 0, 0, 0, 0, 0, 0, 16'h0000, 5'h00, 0, 8'h00)); // 2 IE=04
    vecs.push_back(mk(0, 0, 16'h0000, 8'h00, 5'h00, 1, 0, 0, 0, 0, 0, 16'h0000, 5'h00, 0, 8'h00)); // 3 ei
    vecs.push_back(mk(0, 0, 16'h0000, 8'h00, 5'h04, 0, 0, 0, 0, 1, 0, 16'h0000, 5'h04, 1, 8'h00)); // 4 intt
    vecs.push_back(mk(0, 0, 16'h0000, 8'h00, 5'h00, 0, 0, 0, 0, 1, 0, 16'h0000, 5'h04, 1, 8'h00)); // 5
    vecs.push_back(mk(0, 0, 16'h0000, 8'h00, 5'h00, 0, 0, 0, 1, 0, 1, 16'h0050, 5'h00, 0, 8'h00)); // 6 iack
    vecs.push_back(mk(0, 0, 16'h0000, 8'h00, 5'h00, 0, 0, 0, 0, 0, 0, 16'h0050, 5'h00, 0, 8'h00)); // 7
    vecs.push_back(mk(1, 0, 16'hffff, 8'h1f, 5'h00, 0, 0, 1, 0, 0, 0, 16'h0050, 5'h00, 1, 8'h00)); // 8 IE=1F reti
    vecs.push_back(mk(0, 0, 16'h0000, 8'h00, 5'h09, 0, 0, 0, 0, 1, 0, 16'h0050, 5'h09, 1, 8'h00)); // 9 intv+ints
    vecs.push_back(mk(0, 0, 16'h0000, 8'h00, 5'h00, 0, 0, 0, 1, 0, 1, 16'h0040, 5'h08, 0, 8'h00)); // 10 iack
    vecs.push_back(mk(0, 0, 16'h0000, 8'h00, 5'h00, 0, 0, 1, 0, 1, 0, 16'h0040, 5'h08, 1, 8'h00)); // 11 reti
    vecs.push_back(mk(0, 0, 16'h0000, 8'h00, 5'h00, 0, 0, 0, 1, 0, 1, 16'h0058, 5'h00, 0, 8'h00)); // 12 iack
    vecs.push_back(mk(0, 0, 16'h0000, 8'h00, 5'h00, 0, 0, 0, 0, 0, 0, 16'h0058, 5'h00, 0, 8'h00)); // 13
    vecs.push_back(mk(1, 1, 16'hff0f, 8'h00, 5'h10, 0, 0, 0, 0, 0, 0, 16'h0058, 5'h10, 0, 8'hf0)); // 14 IF=0 vs intj
    vecs.push_back(mk(0, 0, 16'h0000, 8'h00, 5'h00, 0, 0, 1, 0, 1, 0, 16'h0058, 5'h10, 1, 8'h00)); // 15 reti
    vecs.push_back(mk(1, 0, 16'hff0f, 8'h00, 5'h04, 0, 0, 0, 0, 1, 0, 16'h0058, 5'h04, 1, 8'h00)); // 16 IF=0 vs intt
    vecs.push_back(mk(0, 0, 16'h0000, 8'h00, 5'h04, 0, 0, 0, 1, 0, 1, 16'h0050, 5'h04, 0, 8'h00)); // 17 iack+intt
    vecs.push_back(mk(0, 0, 16'h0000, 8'h00, 5'h00, 0, 0, 0, 0, 0, 0, 16'h0050, 5'h04, 0, 8'h00)); // 18
    vecs.push_back(mk(1, 0, 16'hffff, 8'h01, 5'h00, 0, 0, 1, 0, 0, 0, 16'h0050, 5'h04, 1, 8'h00)); // 19 IE=01 reti
    vecs.push_back(mk(1, 0, 16'hff0f, 8'h01, 5'h00, 0, 0, 0, 0, 1, 0, 16'h0050, 5'h01, 1, 8'h00)); // 20 IF=01
    vecs.push_back(mk(1, 0, 16'hff0f, 8'h00, 5'h00, 0, 0, 0, 1, 0, 1, 16'h0000, 5'h00, 0, 8'h00)); // 21 cancelled
    vecs.push_back(mk(0, 0, 16'h0000, 8'h00, 5'h00, 0, 0, 0, 0, 0, 0, 16'h0000, 5'h00, 0, 8'h00)); // 22
    vecs.push_back(mk(0, 0, 16'h0000, 8'h00, 5'h01, 0, 0, 0, 0, 0, 0, 16'h0000, 5'h01, 0, 8'h00)); // 23 intv
    vecs.push_back(mk(0, 0, 16'h0000, 8'h00, 5'h00, 1, 0, 0, 0, 0, 0, 16'h0000, 5'h01, 0, 8'h00)); // 24 ei
    vecs.push_back(mk(0, 0, 16'h0000, 8'h00, 5'h00, 0, 1, 0, 0, 0, 0, 16'h0000, 5'h01, 0, 8'h00)); // 25 di
    vecs.push_back(mk(0, 0, 16'h0000, 8'h00, 5'h00, 0, 0, 0, 0, 0, 0, 16'h0000, 5'h01, 0, 8'h00)); // 26
    vecs.push_back(mk(0, 0, 16'h0000, 8'h00, 5'h00, 0, 0, 0, 0, 0, 0, 16'h0000, 5'h01, 0, 8'h00)); // 27
    vecs.push_back(mk(0, 0, 16'h0000, 8'h00, 5'h00, 0, 0, 0, 1, 0, 1, 16'h0040, 5'h00, 0, 8'h00)); // 28 iack, irq=0
    vecs.push_back(mk(0, 1, 16'hffff, 8'h00, 5'h00, 0, 0, 0, 0, 0, 0, 16'h0040, 5'h00, 0, 8'h01)); // 29 read IE

    // Reset state.
    resetn = 1'b0;
    idle_inputs();
    #12;
    bus_if.load = 1'b1; bus_if.address = 16'hff0f;
    #1 chk("reset_if_read", {8'h00, bus_if.outdata}, 16'h00e0);
    bus_if.address = 16'hffff;
    #1 chk("reset_ie_read", {8'h00, bus_if.outdata}, 16'h0000);
    chk("reset_irq",     {15'h0, irq},    16'h0000);
    chk("reset_ivalid",  {15'h0, ivalid}, 16'h0000);
    chk("reset_ivector", ivector,         16'h0000);
    chk("reset_dif",     {11'h0, dif},    16'h0000);
    chk("reset_dime",    {15'h0, dime},   16'h0000);
    @(negedge clockgb);
    idle_inputs();
    resetn = 1'b1;

    // Table: drive at a falling edge, check at the next falling edge.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(negedge clockgb);
      chk($sformatf("v%0d_irq", i),     {15'h0, irq},              {15'h0, vecs[i].e_irq});
      chk($sformatf("v%0d_ivalid", i),  {15'h0, ivalid},           {15'h0, vecs[i].e_ivalid});
      chk($sformatf("v%0d_ivector", i), ivector,                   vecs[i].e_vec);
      chk($sformatf("v%0d_dif", i),     {11'h0, dif},              {11'h0, vecs[i].e_if});
      chk($sformatf("v%0d_dime", i),    {15'h0, dime},             {15'h0, vecs[i].e_ime});
      chk($sformatf("v%0d_outdata", i), {8'h00, bus_if.outdata},   {8'h00, vecs[i].e_out});
    end

    // Asynchronous reset in the middle of a dispatch.
    idle_inputs();
    bus_if.store = 1'b1; bus_if.address = 16'hffff; bus_if.indata = 8'h1f;
    @(negedge clockgb);
    bus_if.address = 16'hff0f; bus_if.indata = 8'h06;
    @(negedge clockgb);
    idle_inputs();
    iack = 1'b1;
    @(negedge clockgb);
    iack = 1'b0;
    chk("rst_pre_ivalid",  {15'h0, ivalid}, 16'h0001);
    chk("rst_pre_ivector", ivector,         16'h0048);
    chk("rst_pre_dif",     {11'h0, dif},    16'h0004);
    resetn = 1'b0;
    bus_if.load = 1'b1; bus_if.address = 16'hffff;
    #1;
    chk("rst_mid_ivalid",  {15'h0, ivalid}, 16'h0000);
    chk("rst_mid_ivector", ivector,         16'h0000);
    chk("rst_mid_dif",     {11'h0, dif},    16'h0000);
    chk("rst_mid_ie_read", {8'h00, bus_if.outdata}, 16'h0000);
    chk("rst_mid_irq",     {15'h0, irq},    16'h0000);
    @(negedge clockgb);
    resetn = 1'b1;
    bus_if.address = 16'hff0f;
    @(negedge clockgb);
    chk("rst_post_ivalid",  {15'h0, ivalid},          16'h0000);
    chk("rst_post_if_read", {8'h00, bus_if.outdata},  16'h00e0);
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/interrupt_ctrl.md
Name: interrupt_ctrl

Overview:
- Consumer side of the peripheral interrupt-request pulses (timer `intt`, video, LCD STAT, serial, joypad).
- Latches the requests into the IF register at FF0F. Holds the IE mask register at FFFF and the master enable IME.
- Runs a request/acknowledge/vector handshake with the CPU core.
- Sits on the shared OR-combined memory bus next to the timer and other mmap blocks.

Parameters:
- IF_ADDR, 16'hff0f, bus address of interrupt flag register.
- IE_ADDR, 16'hffff, bus address of interrupt enable register.
- VEC_BASE, 16'h0040, vector of bit 0; bit n vector = VEC_BASE + 8*n.

Ports:
- clockgb  in  1  system clock; all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- address  in  16  bus address.
- indata  in  8  bus write data.
- outdata  out  8  bus read data; 0 when not selected.
- load  in  1  bus read strobe.
- store  in  1  bus write strobe.
- intv  in  1  vblank request pulse (IF bit 0).
- intl  in  1  LCD STAT request pulse (bit 1).
- intt  in  1  timer overflow pulse (bit 2).
- ints  in  1  serial request pulse (bit 3).
- intj  in  1  joypad request pulse (bit 4).
- ei  in  1  CPU executed EI, one-cycle pulse.
- di  in  1  CPU executed DI, one-cycle pulse.
- reti  in  1  CPU executed RETI, one-cycle pulse.
- iack  in  1  CPU starts dispatch, one-cycle pulse.
- irq  out  1  interrupt pending to CPU.
- ivector  out  16  dispatch target address.
- ivalid  out  1  ivector valid.
- dif  out  5  debug copy of IF[4:0].
- dime  out  1  debug copy of IME.

Behaviour:
- Reset (async, resetn low):
  - IF=0, IE=0, IME=0, ime_delay=0, state=IDLE.
  - irq=0, ivalid=0, ivector=0, outdata=0.
  - Reset mid-dispatch abandons the dispatch and returns to IDLE.
- Registers:
  - IF is 5 bits.
  - IE is 8 bits. All 8 bits are stored; only [4:0] are used for masking.
- Bus read is combinational, same cycle as load:
  - load && address==IF_ADDR gives {3'b111, IF}.
  - load && address==IE_ADDR gives IE.
  - Otherwise 0.
- Bus write takes effect at the clock edge with store high:
  - IF <= indata[4:0].
  - IE <= indata.
- Request latch:
  - Each int* input high on an edge sets its IF bit.
  - Pulses are edge-sampled, not level-held; a held-high input re-sets the bit every cycle.
- Per-bit priority within one edge: hardware set > dispatch clear > CPU store. A request always survives a same-cycle write of 0 or a dispatch clear.
- pending = IF & IE[4:0].
- IME control:
  - di clears IME immediately, at the next edge.
  - ei sets ime_delay; IME becomes 1 one cycle after the ei edge.
  - di in the cycle after ei cancels the pending enable.
  - reti sets IME at the next edge, with no delay.
  - Dispatch clears IME and ime_delay.
- irq = (state==IDLE) && IME && |pending. It is combinational from registers.
- State machine:
  - IDLE: on iack go to DISPATCH.
    - Latch sel = lowest set bit of pending as sampled on that edge; bit 0 has highest priority.
    - Clear IF[sel] and clear IME.
    - ivector <= VEC_BASE + 8*sel, ivalid <= 1.
    - If pending==0 at the iack edge (cancelled by a same-cycle write): ivector <= 16'h0000, no IF bit is cleared, IME still cleared.
    - iack while irq==0 is legal and handled the same way.
  - DISPATCH: ivalid=1 and ivector held stable. irq forced 0.
    - Next cycle: return to IDLE, ivalid <= 0.
    - iack in DISPATCH is ignored.
- Vector values: bit0 0040, bit1 0048, bit2 0050, bit3 0058, bit4 0060.
- dif = IF, dime = IME, both registered values.

Test Plan:
- Reset then read: load at FF0F -> outdata=8'hE0; load at FFFF -> 8'h00; irq=0, ivalid=0.
- Timer pulse, enable, dispatch:
  - Write IE=8'h04, pulse ei, one-cycle intt -> IF=5'h04; irq=1 from the second cycle after ei.
  - iack -> next cycle ivalid=1, ivector=16'h0050, IF=0, IME=0, irq=0; one cycle later ivalid=0.
- Priority: IE=8'h1F, IME=1, intv and ints pulsed together -> iack gives ivector=0040, IF=5'h08 remaining; reti then a second iack -> ivector=0058, IF=0.
- Same-cycle conflicts:
  - Store IF=8'h00 in the same cycle as an intj pulse -> IF[4]=1.
  - iack edge with intt re-asserting -> IF[2] stays 1 after dispatch.
- Cancelled dispatch: IF=5'h01, IE=1, IME=1; iack in the same cycle as store IF=0 -> ivector=16'h0000, IME=0, IF=0.
- EI/DI timing and reset:
  - ei then di on the next cycle -> IME stays 0, irq never asserts.
  - resetn low during DISPATCH -> ivalid=0, IF=0, IE=0 immediately.
